// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: operand/result handshake bundle for addsub_pipe (adds i_sat when ADDSUB_PIPE_SAT_EN is defined)
interface addsub_pipe_if #(parameter int WIDTH = 32);
  logic             i_valid, o_ready, i_op, i_carry;
  logic             o_valid, i_ready, o_carry, o_overflow;
  logic [WIDTH-1:0] i_data_a, i_data_b, o_result;
`ifdef ADDSUB_PIPE_SAT_EN
  logic             i_sat;
`endif
  modport slave (
`ifdef ADDSUB_PIPE_SAT_EN
    input  i_sat,
`endif
    input  i_valid, i_op, i_carry, i_data_a, i_data_b, i_ready,
    output o_ready, o_valid, o_result, o_carry, o_overflow
  );
  modport master (
`ifdef ADDSUB_PIPE_SAT_EN
    output i_sat,
`endif
    output i_valid, i_op, i_carry, i_data_a, i_data_b, i_ready,
    input  o_ready, o_valid, o_result, o_carry, o_overflow
  );
endinterface

// File: rtl/addsub_pipe.sv
// addsub_pipe: chunked pipelined add/subtract with valid/ready backpressure (ADDSUB_PIPE_SAT_EN enables saturation)
module addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic          i_clk,
  input logic          i_rst,
  addsub_pipe_if.slave bus
);
  localparam int N = WIDTH / CHUNK;
  logic adv, a_msb, b_msb, r_msb, ovf;
  assign adv = !g_st[N-1].vld_q | bus.i_ready;
  assign bus.o_ready = adv;
  for (genvar k = 0; k < N; k++) begin : g_st
    localparam int AW = WIDTH - k * CHUNK;
    logic                   vld_d, op_d, cin_d, vld_q, op_q, c_q;
    logic [AW-1:0]          a_d, b_d;
    logic [(k+1)*CHUNK-1:0] r_d, r_q;
    logic [CHUNK:0]         s;
`ifdef ADDSUB_PIPE_SAT_EN
    logic                   sat_d, sat_q;
`endif
    if (k == 0) begin : g_in
      assign vld_d = bus.i_valid;
      assign op_d  = bus.i_op;
      assign cin_d = bus.i_carry ^ bus.i_op;
      assign a_d   = bus.i_data_a;
      assign b_d   = bus.i_data_b;
      assign r_d   = s[CHUNK-1:0];
`ifdef ADDSUB_PIPE_SAT_EN
      assign sat_d = bus.i_sat;
`endif
    end else begin : g_mid
      assign vld_d = g_st[k-1].vld_q;
      assign op_d  = g_st[k-1].op_q;
      assign cin_d = g_st[k-1].c_q;
      assign a_d   = g_st[k-1].g_fwd.a_q;
      assign b_d   = g_st[k-1].g_fwd.b_q;
      assign r_d   = {s[CHUNK-1:0], g_st[k-1].r_q};
`ifdef ADDSUB_PIPE_SAT_EN
      assign sat_d = g_st[k-1].sat_q;
`endif
    end
    assign s = {1'b0, a_d[CHUNK-1:0]} + {1'b0, b_d[CHUNK-1:0] ^ {CHUNK{op_d}}} + {{CHUNK{1'b0}}, cin_d};
    // resolve this slice and register its carry, control and accumulated low result bits
    always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
        vld_q <= 1'b0;
        op_q  <= 1'b0;
        c_q   <= 1'b0;
        r_q   <= '0;
`ifdef ADDSUB_PIPE_SAT_EN
        sat_q <= 1'b0;
`endif
      end else if (adv) begin
        vld_q <= vld_d;
        op_q  <= op_d;
        c_q   <= s[CHUNK];
        r_q   <= r_d;
`ifdef ADDSUB_PIPE_SAT_EN
        sat_q <= sat_d;
`endif
      end
    if (k == N - 1) begin : g_last
      logic as_q, bs_q;
      // keep only the operand sign bits for overflow detection at the output
      always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
          as_q <= 1'b0;
          bs_q <= 1'b0;
        end else if (adv) begin
          as_q <= a_d[AW-1];
          bs_q <= b_d[AW-1];
        end
    end else begin : g_fwd
      logic [AW-CHUNK-1:0] a_q, b_q;
      // skew the still-unconsumed upper operand slices along with their operation
      always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d[AW-1:CHUNK];
          b_q <= b_d[AW-1:CHUNK];
        end
    end
  end
  assign a_msb          = g_st[N-1].g_last.as_q;
  assign b_msb          = g_st[N-1].g_last.bs_q;
  assign r_msb          = g_st[N-1].r_q[WIDTH-1];
  assign ovf            = (a_msb == (b_msb ^ g_st[N-1].op_q)) & (r_msb != a_msb);
  assign bus.o_valid    = g_st[N-1].vld_q;
  assign bus.o_carry    = g_st[N-1].c_q ^ g_st[N-1].op_q;
  assign bus.o_overflow = ovf;
`ifdef ADDSUB_PIPE_SAT_EN
  assign bus.o_result   = (g_st[N-1].sat_q & ovf) ? {a_msb, {(WIDTH-1){!a_msb}}} : g_st[N-1].r_q;
`else
  assign bus.o_result   = g_st[N-1].r_q;
`endif
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed self-checking bench for addsub_pipe at WIDTH=32, CHUNK=8
module tb_addsub_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
`ifdef ADDSUB_PIPE_SAT_EN
  localparam logic [31:0] R_OVA = 32'h7FFF_FFFF;
  localparam logic [31:0] R_OVS = 32'h8000_0000;
`else
  localparam logic [31:0] R_OVA = 32'h8000_0000;
  localparam logic [31:0] R_OVS = 32'h7FFF_FFFF;
`endif

  addsub_pipe_if #(.WIDTH(32)) bus ();
  addsub_pipe #(.WIDTH(32), .CHUNK(8)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic op, input logic c, input logic [31:0] a, input logic [31:0] b);
    bus.i_valid  = v;
    bus.i_op     = op;
    bus.i_carry  = c;
    bus.i_data_a = a;
    bus.i_data_b = b;
`ifdef ADDSUB_PIPE_SAT_EN
    bus.i_sat    = 1'b0;
`endif
  endtask

  // reference: {overflow, carry/borrow, result} from wide signed/unsigned arithmetic
  function automatic logic [33:0] model(input logic op, input logic c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] t;
    longint      sv;
    logic        ov;
    t  = op ? ({1'b0, a} - {1'b0, b} - {32'b0, c}) : ({1'b0, a} + {1'b0, b} + {32'b0, c});
    sv = op ? (longint'($signed(a)) - longint'($signed(b)) - longint'(c))
            : (longint'($signed(a)) + longint'($signed(b)) + longint'(c));
    ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    return {ov, t};
  endfunction

  task automatic test_reset();
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.o_result); end
    checks++; if (bus.o_carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", bus.o_carry); end
    checks++; if (bus.o_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.o_overflow); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
  endtask

  task automatic test_arith();
    logic        op_v [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        c_v  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] a_v  [7] = '{32'h0000_00FF, 32'h0, 32'd5, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_FFFF};
    logic [31:0] b_v  [7] = '{32'h1, 32'h1, 32'd3, 32'h1, 32'h1, 32'h1, 32'h0};
    logic [31:0] r_v  [7] = '{32'h0000_0100, 32'hFFFF_FFFF, 32'h1, R_OVA, R_OVS, 32'h0, 32'h0001_0000};
    logic        co_v [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        ov_v [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(1'b1, op_v[i], c_v[i], a_v[i], b_v[i]);
`ifdef ADDSUB_PIPE_SAT_EN
      bus.i_sat = 1'b1;
`endif
      @(negedge clk);
      bus.i_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL arith%0d_early_valid got=%b exp=0", i, bus.o_valid); end
      @(negedge clk);
      checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL arith%0d_valid got=%b exp=1", i, bus.o_valid); end
      checks++; if (bus.o_result !== r_v[i]) begin failures++; $display("FAIL arith%0d_result got=%h exp=%h", i, bus.o_result, r_v[i]); end
      checks++; if (bus.o_carry !== co_v[i]) begin failures++; $display("FAIL arith%0d_carry got=%b exp=%b", i, bus.o_carry, co_v[i]); end
      checks++; if (bus.o_overflow !== ov_v[i]) begin failures++; $display("FAIL arith%0d_overflow got=%b exp=%b", i, bus.o_overflow, ov_v[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic        op_r [8];
    logic        c_r  [8];
    logic [31:0] a_r  [8];
    logic [31:0] b_r  [8];
    logic [33:0] q [$];
    logic [33:0] held, exp;
    logic        stall_prev = 1'b0;
    int          sent = 0;
    int          got = 0;
    for (int i = 0; i < 8; i++) begin
      op_r[i] = 1'($urandom_range(0, 1));
      c_r[i]  = 1'($urandom_range(0, 1));
      a_r[i]  = $urandom;
      b_r[i]  = $urandom;
    end
    held = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      bus.i_ready = !(c >= 5 && c < 8);
      if (sent < 8) drive(1'b1, op_r[sent], c_r[sent], a_r[sent], b_r[sent]);
      else bus.i_valid = 1'b0;
      #1;
      if (!bus.i_ready && bus.o_valid) begin
        checks++; if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_ready cyc=%0d got=%b exp=0", c, bus.o_ready); end
        if (stall_prev) begin
          checks++;
          if ({bus.o_overflow, bus.o_carry, bus.o_result} !== held) begin
            failures++; $display("FAIL b2b_stall_hold cyc=%0d got=%h exp=%h", c, {bus.o_overflow, bus.o_carry, bus.o_result}, held);
          end
        end
        held = {bus.o_overflow, bus.o_carry, bus.o_result};
        stall_prev = 1'b1;
      end else stall_prev = 1'b0;
      if (bus.o_valid && bus.i_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL b2b_unexpected_output cyc=%0d got=%h exp=none", c, bus.o_result);
        end else begin
          exp = q.pop_front();
          if ({bus.o_overflow, bus.o_carry, bus.o_result} !== exp) begin
            failures++; $display("FAIL b2b_result%0d got=%h exp=%h", got, {bus.o_overflow, bus.o_carry, bus.o_result}, exp);
          end
        end
        got++;
      end
      if (bus.i_valid && bus.o_ready) begin
        q.push_back(model(op_r[sent], c_r[sent], a_r[sent], b_r[sent]));
        sent++;
      end
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    checks++; if (got != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", got); end
    repeat (5) begin
      @(negedge clk);
      checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL b2b_extra_output got=%b exp=0", bus.o_valid); end
    end
  endtask

  task automatic test_bubbles();
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic exp;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c < 5) drive(pat[c], 1'b0, 1'b0, 32'(c), 32'(c));
      else bus.i_valid = 1'b0;
      #1;
      exp = 1'b0;
      if (c >= 4) exp = pat[c-4];
      checks++; if (bus.o_valid !== exp) begin failures++; $display("FAIL bubble_cyc%0d got=%b exp=%b", c, bus.o_valid, exp); end
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 32'(c + 1), 32'd10);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%b exp=1", bus.o_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_result !== 32'h0) begin failures++; $display("FAIL rstmid_result got=%h exp=0", bus.o_result); end
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", bus.o_ready); end
    repeat (6) begin
      @(negedge clk);
      if (bus.o_valid) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rstmid_ghost_outputs got=%0d exp=0", seen); end
    drive(1'b1, 1'b0, 1'b0, 32'd12, 32'd30);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL rstmid_new_valid got=%b exp=1", bus.o_valid); end
    checks++; if (bus.o_result !== 32'd42) begin failures++; $display("FAIL rstmid_new_result got=%h exp=%h", bus.o_result, 32'd42); end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.i_ready = 1'b1;
    test_reset();
    test_arith();
    test_back_to_back();
    test_bubbles();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
